fifo_ctrl_fsm_param: RTL and testbench
======================================

Name: fifo_ctrl_fsm_param

Overview:
Parametrised control FSM for the FIFO switch datapath (main FIFO, VC0/VC1, D0/D1 and future channels). It sequences RESET -> INIT -> IDLE <-> ACTIVE -> ERROR and latches per-FIFO low/high almost-empty/almost-full thresholds during INIT. It adds the following over the fixed 5-FIFO controller:
- generic channel count and threshold width
- re-init from IDLE
- debounced ACTIVE->IDLE return
- sticky per-FIFO error source capture

Parameters:
NUM_FIFOS, 5, number of FIFOs monitored (>=1)
THR_W, 5, width of each threshold field
IDLE_DLY, 4, consecutive all-empty cycles in ACTIVE before returning to IDLE (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
init  input  1  configuration request; thresholds loaded while in INIT
thr_low_in  input  NUM_FIFOS*THR_W  low thresholds, FIFO i at bits [i*THR_W +: THR_W]
thr_high_in  input  NUM_FIFOS*THR_W  high thresholds, same packing
empties  input  NUM_FIFOS  per-FIFO empty flag, 1 = empty
errors  input  NUM_FIFOS  per-FIFO error flag, 1 = overflow/underflow
thr_low_out  output  NUM_FIFOS*THR_W  latched low thresholds
thr_high_out  output  NUM_FIFOS*THR_W  latched high thresholds
idle_out  output  1  1 iff state==IDLE
active_out  output  1  1 iff state==ACTIVE
error_out  output  1  1 iff state==ERROR
state_out  output  3  encoded state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4
err_src  output  NUM_FIFOS  sticky OR of errors captured since reset

Behaviour:
- Reset:
  - reset=1 at a clock edge: state<=RESET, thr_low_out/thr_high_out<=0, err_src<=0, idle counter<=0.
  - Applies from any state, including mid-ACTIVE or ERROR.
- Outputs:
  - idle_out/active_out/error_out/state_out are pure Moore decodes of the state register; no combinational path from inputs.
  - The resulting flags change in the cycle after the causing input is sampled.
- Definitions: all_empty = &empties; any_err = |errors.
- RESET: -> INIT unconditionally on the next edge with reset=0.
- INIT:
  - Every cycle in INIT, all thr_*_out registers load from thr_*_in.
  - init=0 -> IDLE; the last load happens on that transition edge.
  - init=1 -> stay in INIT.
  - errors are ignored in INIT.
- IDLE, priority order:
  1. any_err -> ERROR
  2. init=1 -> INIT (re-configuration; thresholds reload)
  3. !all_empty -> ACTIVE
  4. else stay in IDLE
- ACTIVE:
  - any_err -> ERROR, with priority over all else; init is ignored.
  - Idle counter, width $clog2(IDLE_DLY+1):
    - increments on each ACTIVE cycle with all_empty=1;
    - clears when all_empty=0 or when state!=ACTIVE.
  - Transition to IDLE on the edge where all_empty=1 and counter==IDLE_DLY-1, i.e. after exactly IDLE_DLY consecutive all-empty cycles.
  - Counter saturates and never wraps.
- ERROR: stays in ERROR until reset=1; init, empties and errors have no effect on state.
- err_src:
  - In IDLE, ACTIVE and ERROR: err_src <= err_src | errors each cycle.
  - Not updated in RESET or INIT.
  - Cleared only by reset.
- Thresholds: stable outside INIT. Values are not range-checked unless the optional feature is enabled.
- Illegal state encodings: next state is RESET.

Optional Feature:
- Macro: FIFO_CTRL_THR_CHECK_EN.
- When defined:
  - On the INIT->IDLE edge, if any FIFO has thr_low_in[i] >= thr_high_in[i], the FSM goes to ERROR instead of IDLE.
  - Thresholds are still latched.
  - An extra output cfg_err (1 bit, reset 0, sticky until reset) is set.
  - err_src is unaffected.
- When not defined: no check, no cfg_err port, and INIT always exits to IDLE.

Test Plan:
1. Reset then INIT: reset=1 for 2 cycles, then reset=0 with init=1, thr_low_in FIFO0=3 / thr_high_in FIFO0=20 (all fields), then init=0.
   -> state_out 0 -> 1 -> 2; thr_low_out FIFO0=3, thr_high_out FIFO0=20; idle_out=1 one cycle after init drops.
2. IDLE->ACTIVE->IDLE debounce (IDLE_DLY=4): empties=5'b11011 for 1 cycle.
   -> active_out=1 next cycle. Then empties=5'b11111 for 3 cycles, 5'b11110 for 1, 5'b11111 for 4.
   -> stays ACTIVE until the 4th consecutive all-empty cycle; idle_out=1 on the following cycle.
3. Error capture: in ACTIVE, errors=5'b00100 for one cycle, then 5'b01000 while in ERROR.
   -> error_out=1 next cycle and stays; err_src=5'b01100; init toggling has no effect.
4. Re-init and reset mid-operation:
   - In IDLE, init=1 with new thr_high_in=25 -> INIT, then IDLE with thr_high_out=25.
   - In ERROR, reset=1 for one cycle -> state_out=0, err_src=0, thresholds 0.
5. Priority: in IDLE assert errors=5'b00001, init=1 and empties=5'b00000 in the same cycle -> ERROR, not INIT or ACTIVE.
6. With FIFO_CTRL_THR_CHECK_EN defined: INIT with FIFO3 low=10, high=10, then init=0 -> error_out=1, cfg_err=1, idle_out stays 0.

Source files
------------

// File: rtl/fifo_ctrl_fsm_param.sv
// ============================================================================
// Module   : fifo_ctrl_fsm_param
// Brief    : Parametrised FIFO-switch control FSM with threshold latching,
//            debounced ACTIVE->IDLE return and sticky error-source capture.
//            Optional macro FIFO_CTRL_THR_CHECK_EN adds low<high config check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctrl_fsm_param #(
    parameter int NUM_FIFOS = 5,
    parameter int THR_W     = 5,
    parameter int IDLE_DLY  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [NUM_FIFOS*THR_W-1:0] thr_low_in,
    input  logic [NUM_FIFOS*THR_W-1:0] thr_high_in,
    input  logic [NUM_FIFOS-1:0]       empties,
    input  logic [NUM_FIFOS-1:0]       errors,
    output logic [NUM_FIFOS*THR_W-1:0] thr_low_out,
    output logic [NUM_FIFOS*THR_W-1:0] thr_high_out,
    output logic                       idle_out,
    output logic                       active_out,
    output logic                       error_out,
    output logic [2:0]                 state_out,
    output logic [NUM_FIFOS-1:0]       err_src
`ifdef FIFO_CTRL_THR_CHECK_EN
    ,
    output logic                       cfg_err
`endif
);

    localparam int CNT_W = $clog2(IDLE_DLY + 1);
    localparam logic [CNT_W-1:0] c_IDLE_LAST = CNT_W'(IDLE_DLY - 1);
    localparam logic [CNT_W-1:0] c_IDLE_MAX  = CNT_W'(IDLE_DLY);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_idle_cnt;
    logic             w_all_empty;
    logic             w_any_err;

    assign w_all_empty = &empties;
    assign w_any_err   = |errors;

    // Flags decode the state register only, so they never see input glitches.
    assign state_out  = r_state;
    assign idle_out   = (r_state == S_IDLE);
    assign active_out = (r_state == S_ACTIVE);
    assign error_out  = (r_state == S_ERROR);

`ifdef FIFO_CTRL_THR_CHECK_EN
    logic [NUM_FIFOS-1:0] w_thr_bad;
    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_thr_chk
        assign w_thr_bad[i] = (thr_low_in[i*THR_W +: THR_W] >= thr_high_in[i*THR_W +: THR_W]);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_RESET;
            r_idle_cnt   <= '0;
            thr_low_out  <= '0;
            thr_high_out <= '0;
            err_src      <= '0;
`ifdef FIFO_CTRL_THR_CHECK_EN
            cfg_err      <= 1'b0;
`endif
        end else begin
            // Saturating run-length of consecutive all-empty ACTIVE cycles.
            if (r_state == S_ACTIVE && w_all_empty) begin
                if (r_idle_cnt != c_IDLE_MAX) begin
                    r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                end
            end else begin
                r_idle_cnt <= '0;
            end

            if (r_state == S_IDLE || r_state == S_ACTIVE || r_state == S_ERROR) begin
                err_src <= err_src | errors;
            end

            case (r_state)
                S_RESET: r_state <= S_INIT;
                S_INIT: begin
                    thr_low_out  <= thr_low_in;
                    thr_high_out <= thr_high_in;
                    if (!init) begin
`ifdef FIFO_CTRL_THR_CHECK_EN
                        if (|w_thr_bad) begin
                            r_state <= S_ERROR;
                            cfg_err <= 1'b1;
                        end else
`endif
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_any_err) begin
                        r_state <= S_ERROR;
                    end else if (init) begin
                        r_state <= S_INIT;
                    end else if (!w_all_empty) begin
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_any_err) begin
                        r_state <= S_ERROR;
                    end else if (w_all_empty && r_idle_cnt == c_IDLE_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ERROR: r_state <= S_ERROR;
                default: r_state <= S_RESET;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl_fsm_param.sv
// ============================================================================
// Module   : tb_fifo_ctrl_fsm_param
// Brief    : Directed plus randomized bench for fifo_ctrl_fsm_param against a
//            behavioural model; honours FIFO_CTRL_THR_CHECK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctrl_fsm_param;

    localparam int NF  = 5;
    localparam int TW  = 5;
    localparam int DLY = 4;
    localparam int W   = NF * TW;
`ifdef FIFO_CTRL_THR_CHECK_EN
    localparam bit c_CHECK_EN = 1'b1;
`else
    localparam bit c_CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, init;
    logic [W-1:0]  thr_low_in, thr_high_in, thr_low_out, thr_high_out;
    logic [NF-1:0] empties, errors, err_src;
    logic          idle_out, active_out, error_out;
    logic [2:0]    state_out;
`ifdef FIFO_CTRL_THR_CHECK_EN
    logic          cfg_err;
`endif

    always #5 clk = ~clk;

    fifo_ctrl_fsm_param #(.NUM_FIFOS(NF), .THR_W(TW), .IDLE_DLY(DLY)) dut (
        .clk(clk), .reset(reset), .init(init),
        .thr_low_in(thr_low_in), .thr_high_in(thr_high_in),
        .empties(empties), .errors(errors),
        .thr_low_out(thr_low_out), .thr_high_out(thr_high_out),
        .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
        .state_out(state_out), .err_src(err_src)
`ifdef FIFO_CTRL_THR_CHECK_EN
        , .cfg_err(cfg_err)
`endif
    );

    // Behavioural model: state by number, plus a plain count of consecutive
    // all-empty cycles spent in ACTIVE.
    int            m_state;
    int            m_run;
    logic [W-1:0]  m_lo, m_hi;
    logic [NF-1:0] m_src;
    logic          m_cfg;
    int            n_cmp  = 0;
    int            n_fail = 0;

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] r;
        for (int i = 0; i < NF; i++) r[i*TW +: TW] = TW'(v);
        return r;
    endfunction

    function automatic bit any_bad(input logic [W-1:0] lo, input logic [W-1:0] hi);
        bit b = 1'b0;
        for (int i = 0; i < NF; i++)
            if (int'(lo[i*TW +: TW]) >= int'(hi[i*TW +: TW])) b = 1'b1;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit all_e = (empties == {NF{1'b1}});
        bit any_e = (errors != '0);
        if (reset) begin
            m_state = 0; m_run = 0; m_lo = '0; m_hi = '0; m_src = '0; m_cfg = 1'b0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    m_lo = thr_low_in;
                    m_hi = thr_high_in;
                    if (!init) begin
                        if (c_CHECK_EN && any_bad(thr_low_in, thr_high_in)) begin
                            m_state = 4; m_cfg = 1'b1;
                        end else m_state = 2;
                    end
                end
                2: begin
                    m_src = m_src | errors;
                    if (any_e) m_state = 4;
                    else if (init) m_state = 1;
                    else if (!all_e) begin m_state = 3; m_run = 0; end
                end
                3: begin
                    m_src = m_src | errors;
                    if (any_e) m_state = 4;
                    else if (all_e) begin
                        m_run++;
                        if (m_run == DLY) m_state = 2;
                    end else m_run = 0;
                end
                default: m_src = m_src | errors;
            endcase
        end
    endtask

    task automatic check_all();
        chk("state_out", state_out, m_state);
        chk("idle_out", idle_out, m_state == 2);
        chk("active_out", active_out, m_state == 3);
        chk("error_out", error_out, m_state == 4);
        chk("thr_low_out", thr_low_out, m_lo);
        chk("thr_high_out", thr_high_out, m_hi);
        chk("err_src", err_src, m_src);
`ifdef FIFO_CTRL_THR_CHECK_EN
        chk("cfg_err", cfg_err, m_cfg);
`endif
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            check_all();
        end
    endtask

    initial begin
        logic [W-1:0] lo6, hi6;
        m_state = 0; m_run = 0; m_lo = '0; m_hi = '0; m_src = '0; m_cfg = 1'b0;
        reset = 1'b1; init = 1'b0; thr_low_in = '0; thr_high_in = '0;
        empties = '1; errors = '0;

        // Reset then INIT
        step(2);
        chk("t1_reset_state", state_out, 0);
        reset = 1'b0; init = 1'b1; thr_low_in = fill(3); thr_high_in = fill(20);
        step(1);
        chk("t1_init_state", state_out, 1);
        step(1);
        init = 1'b0;
        step(1);
        chk("t1_idle_state", state_out, 2);
        chk("t1_idle_flag", idle_out, 1);
        chk("t1_lo0", thr_low_out[TW-1:0], 3);
        chk("t1_hi0", thr_high_out[TW-1:0], 20);

        // Debounced ACTIVE->IDLE
        empties = 5'b11011; step(1);
        chk("t2_active", active_out, 1);
        empties = 5'b11111; step(3);
        chk("t2_active_after3", active_out, 1);
        empties = 5'b11110; step(1);
        empties = 5'b11111; step(3);
        chk("t2_active_after3b", active_out, 1);
        step(1);
        chk("t2_idle_after4", idle_out, 1);

        // Re-init from IDLE
        init = 1'b1; thr_high_in = fill(25); step(1);
        chk("t4_reinit_state", state_out, 1);
        init = 1'b0; step(1);
        chk("t4_reidle", idle_out, 1);
        chk("t4_hi4", thr_high_out[W-1 -: TW], 25);

        // Error capture from ACTIVE
        empties = '0; step(1);
        empties = '1; errors = 5'b00100; step(1);
        chk("t3_error", error_out, 1);
        errors = 5'b01000; init = 1'b1; step(1);
        init = 1'b0; step(1);
        init = 1'b1; step(1);
        errors = '0; init = 1'b0; step(1);
        chk("t3_error_held", error_out, 1);
        chk("t3_err_src", err_src, 5'b01100);

        // Reset from ERROR
        reset = 1'b1; step(1);
        chk("t4_rst_state", state_out, 0);
        chk("t4_rst_src", err_src, 0);
        chk("t4_rst_thr", thr_high_out, 0);
        reset = 1'b0; init = 1'b1; step(2);
        init = 1'b0; step(1);

        // Priority: error beats init and non-empty
        errors = 5'b00001; init = 1'b1; empties = '0; step(1);
        chk("t5_prio", state_out, 4);
        errors = '0; init = 1'b0; empties = '1;

`ifdef FIFO_CTRL_THR_CHECK_EN
        reset = 1'b1; step(1);
        reset = 1'b0; init = 1'b1;
        lo6 = fill(3); hi6 = fill(20);
        lo6[3*TW +: TW] = TW'(10); hi6[3*TW +: TW] = TW'(10);
        thr_low_in = lo6; thr_high_in = hi6;
        step(2);
        init = 1'b0; step(1);
        chk("t6_error", error_out, 1);
        chk("t6_cfg_err", cfg_err, 1);
        chk("t6_not_idle", idle_out, 0);
`else
        lo6 = '0; hi6 = '0;
        thr_low_in = lo6; thr_high_in = hi6;
`endif

        // Randomized phase
        reset = 1'b1; step(1);
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 59) == 0);
            init    = ($urandom_range(0, 7) == 0);
            empties = ($urandom_range(0, 1) == 1) ? {NF{1'b1}} : NF'($urandom);
            errors  = ($urandom_range(0, 79) == 0) ? NF'(1 << $urandom_range(0, NF - 1)) : '0;
            if ($urandom_range(0, 15) == 0) begin
                thr_low_in  = W'($urandom);
                thr_high_in = ($urandom_range(0, 3) == 0) ? W'($urandom) : fill(31);
            end
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
